// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: widths, FSM states and the
// priority decoder for the memory/stack operation requested by the EM register.
package memory_stage_pkg;

  localparam int DATA_WIDTH         = 16;
  localparam int SP_WIDTH           = 32;
  localparam int DEFAULT_ADDR_WIDTH = 12;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT2 = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } op_e;

  // Only one operation is honoured per instruction: push > pop > write > read.
  function automatic op_e decode_op(
    input logic valid,
    input logic push,
    input logic pop,
    input logic write,
    input logic read
  );
    if (!valid)     return OP_NONE;
    else if (push)  return OP_PUSH;
    else if (pop)   return OP_POP;
    else if (write) return OP_WRITE;
    else if (read)  return OP_READ;
    else            return OP_NONE;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Data memory for the memory stage: 2**ADDR_WIDTH x 16 words, two asynchronous
// read ports (the second serves the high word of a 32-bit pop) and one synchronous write port.
module memory_stage_data_memory
  import memory_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the storage array deliberately has no reset; resetting a RAM forces
  // it into flops and its contents are undefined after power-up anyway.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/memory_stage.sv
// Memory (M) stage: LD/ST on the data memory, 16-bit PUSH/POP and two-beat
// 32-bit stack transfers. Optional stack bounds checking with STACK_GUARD_EN.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int                  ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [SP_WIDTH-1:0] SP_RESET   = SP_WIDTH'((1 << ADDR_WIDTH) - 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  push_in,
  input  logic                  pop_in,
  input  logic                  wide_in,
  input  logic [15:0]           addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic [SP_WIDTH-1:0]   wdata32_in,
  output logic                  stall_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic [SP_WIDTH-1:0]   rdata32_out,
  output logic [SP_WIDTH-1:0]   sp_out,
  output logic                  stack_fault_out
);

  state_e                state, state_next;
  logic [SP_WIDTH-1:0]   sp, sp_next;
  logic [DATA_WIDTH-1:0] lo_hold;
  logic                  lo_capture;

  op_e                   op;
  logic [SP_WIDTH-1:0]   step;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] sp_addr;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr, raddr_a, raddr_b;
  logic [DATA_WIDTH-1:0] wdata, rdata_a, rdata_b;

  logic                  stall, valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [SP_WIDTH-1:0]   rdata32;

  // Only the low ADDR_WIDTH bits of the effective address reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_in[15:ADDR_WIDTH];

  assign op      = decode_op(valid_in, push_in, pop_in, mem_write_in, mem_read_in);
  assign step    = wide_in ? SP_WIDTH'(2) : SP_WIDTH'(1);
  assign sp_addr = sp[ADDR_WIDTH-1:0];

`ifdef STACK_GUARD_EN
  // Compare in 33 bits so a pop near 2**32 cannot wrap past the bound.
  always_comb begin
    fault = 1'b0;
    if (op == OP_PUSH)
      fault = (sp < step);
    else if (op == OP_POP)
      fault = (({1'b0, sp} + {1'b0, step}) > {1'b0, SP_RESET});
  end
`else
  assign fault = 1'b0;
`endif

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = ST_IDLE;
    sp_next    = sp;
    we         = 1'b0;
    waddr      = addr_in[ADDR_WIDTH-1:0];
    wdata      = wdata_in;
    raddr_a    = addr_in[ADDR_WIDTH-1:0];
    raddr_b    = sp_addr + ADDR_WIDTH'(2);
    lo_capture = 1'b0;
    stall      = 1'b0;
    valid      = valid_in;
    rdata      = '0;
    rdata32    = '0;

    case (op)
      OP_READ: begin
        rdata = rdata_a;
      end

      OP_WRITE: begin
        we = 1'b1;
      end

      OP_PUSH: begin
        if (!fault) begin
          we    = 1'b1;
          waddr = sp_addr;
          if (!wide_in) begin
            sp_next = sp - SP_WIDTH'(1);
          end else if (state == ST_IDLE) begin
            wdata      = wdata32_in[31:16];
            stall      = 1'b1;
            valid      = 1'b0;
            state_next = ST_BEAT2;
          end else begin
            waddr   = sp_addr - ADDR_WIDTH'(1);
            wdata   = wdata32_in[15:0];
            sp_next = sp - SP_WIDTH'(2);
          end
        end
      end

      OP_POP: begin
        raddr_a = sp_addr + ADDR_WIDTH'(1);
        if (!fault) begin
          if (!wide_in) begin
            rdata   = rdata_a;
            sp_next = sp + SP_WIDTH'(1);
          end else if (state == ST_IDLE) begin
            // Low word is parked so the second beat can read the high word.
            lo_capture = 1'b1;
            stall      = 1'b1;
            valid      = 1'b0;
            state_next = ST_BEAT2;
          end else begin
            rdata32 = {rdata_b, lo_hold};
            sp_next = sp + SP_WIDTH'(2);
          end
        end
      end

      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp      <= SP_RESET;
      state   <= ST_IDLE;
      lo_hold <= '0;
    end else begin
      sp    <= sp_next;
      state <= state_next;
      if (lo_capture) lo_hold <= rdata_a;
    end
  end

  memory_stage_data_memory #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_data_memory (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  // Outputs are forced to their idle values while reset is held.
  assign stall_out       = reset & stall;
  assign valid_out       = reset & valid;
  assign rdata_out       = reset ? rdata   : '0;
  assign rdata32_out     = reset ? rdata32 : '0;
  assign sp_out          = reset ? sp_next : SP_RESET;
  assign stack_fault_out = reset & fault;

endmodule
